pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed-field inter-stage registers, such as the decode-to-execute register, throughout the core. It carries an opaque payload of PAYLOAD_W bits with a valid/ready handshake in both directions. Stall is expressed by back-pressure instead of a zeroing hold, and an optional 2-entry skid buffer makes `in_ready` a pure register output. It also provides a synchronous flush that inserts a bubble, and a saturating stall-cycle counter for performance monitoring.

## Interface
- PAYLOAD_W, 64: payload width in bits (op type, register indices, offset, immediate, packed by the instantiating stage).
- SKID, 1: 1 selects a 2-entry buffer with registered `in_ready`; 0 selects a 1-entry buffer with combinational `in_ready`.
- CNT_W, 16: stall counter width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage accepts a payload this cycle.
- in_data  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  stage presents a payload.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  PAYLOAD_W  presented payload; all-zero (NOP) whenever out_valid=0.
- flush  in  1  synchronous kill of all held and incoming payloads (branch mispredict/trap).
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Transfers: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready.
- Storage is a main register driving out_data, plus a skid register when SKID=1.
- SKID=1 uses a state machine with states EMPTY, ONE and TWO:
  - EMPTY, in-transfer: go to ONE, main <= in_data.
  - ONE, in-transfer and out-transfer: stay in ONE, main <= in_data.
  - ONE, in-transfer only: go to TWO, skid <= in_data.
  - ONE, out-transfer only: go to EMPTY, main <= 0.
  - TWO, out-transfer: go to ONE, main <= skid, skid <= 0. No in-transfer is possible in TWO.
  - in_ready = (state != TWO), taken from a register.
- SKID=0 uses EMPTY and ONE only:
  - in_ready = ~out_valid | out_ready, combinational.
  - Same-cycle in-transfer and out-transfer replaces main.
- Ordering is strictly FIFO. No payload is ever duplicated or dropped, except by flush.
- Flush has highest priority:
  - Next state is EMPTY and main/skid are zeroed.
  - An in-transfer in the flush cycle is discarded; upstream treats it as consumed.
  - An out-transfer in the flush cycle completes normally downstream.
- stall_cnt:
  - Increments when out_valid & ~out_ready and stall_cnt != all-ones; holds at 2^CNT_W-1.
  - cnt_clr takes priority over the increment, loading 0.
  - Flush does not clear the counter.

## Timing
- Reset values (asynchronous, immediate):
  - state = EMPTY, out_valid = 0, out_data = 0, skid = 0, stall_cnt = 0.
  - in_ready = 1 for SKID=1; it follows the EMPTY state for SKID=0.
- Latency: a payload accepted at edge N is presented with out_valid=1 after edge N, i.e. one cycle.
- Throughput: one payload per cycle while out_ready=1, for both SKID values.
- SKID=1 back-pressure:
  - out_ready falling while in ONE still allows one more in-transfer into skid.
  - in_ready drops the cycle after that transfer.
- Reset asserted mid-operation empties the stage immediately. Held payloads are lost, with no partial output.
- flush and rst share no path; flush acts only on rising edges.

## Structure
- Shared package `pipe_pkg`:
  - State encoding localparams PS_EMPTY=2'd0, PS_ONE=2'd1, PS_TWO=2'd2.
  - Common payload field widths.
- Sub-module `sat_counter` (params W; ports clk, rst, inc, clr, q), reused by other performance counters.
- SKID selects between the two storage variants through a generate block in one module.
- Stage-specific packing/unpacking of fields lives in the instantiating stage, not here.

## Test plan
- Reset: rst pulsed mid-stream with two payloads held (SKID=1) -> out_valid=0, out_data=0, stall_cnt=0 and in_ready=1 immediately, and after release.
- Streaming: out_ready=1, in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, back-to-back, with out_valid continuously 1.
- Skid: SKID=1; send 0xA then 0xB while out_ready=0 -> in_ready=0 after 0xB. Then raise out_ready -> 0xA, then 0xB, with no loss.
- SKID=0 back-pressure: hold out_ready=0 with the stage in ONE -> in_ready=0 in the same cycle. Raise out_ready with in_valid=1 -> payload replaced in the same cycle.
- Flush: flush asserted while in TWO with in_valid=1 -> next cycle out_valid=0 and out_data=0. The incoming payload never appears.
- Counter: CNT_W=4 with out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 15. A cnt_clr concurrent with a stall cycle -> 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage registers.
//   - ps_state_e : occupancy state of a pipe_stage_reg (EMPTY / ONE / TWO)
//   - payload field widths used by stages when packing their payloads
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } ps_state_e;

    // Common payload field widths; packing happens in the instantiating stage.
    localparam int unsigned OP_W     = 6;
    localparam int unsigned REGIDX_W = 5;
    localparam int unsigned OFFSET_W = 16;
    localparam int unsigned IMM_W    = 32;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter for performance monitoring.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears q
//   inc : count one event this cycle (ignored once q is all-ones)
//   clr : synchronous clear, wins over inc
//   q   : current count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with opaque payload.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_valid   : upstream offers in_data
//   in_ready   : stage accepts this cycle (registered when SKID=1)
//   in_data    : upstream payload
//   out_valid  : stage presents out_data
//   out_ready  : downstream consumes this cycle
//   out_data   : presented payload, all-zero whenever out_valid=0
//   flush      : synchronous kill of held and incoming payloads
//   cnt_clr    : synchronous clear of stall_cnt
//   stall_cnt  : saturating count of cycles with out_valid & ~out_ready
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 64,
    parameter bit          SKID      = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 flush,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     stall_cnt
);

    generate
        if (SKID) begin : g_skid
            ps_state_e            state_q, state_d;
            logic [PAYLOAD_W-1:0] main_q, main_d;
            logic [PAYLOAD_W-1:0] skid_q, skid_d;
            logic                 in_ready_q, in_ready_d;
            logic                 in_xfer, out_xfer;

            assign in_xfer  = in_valid & in_ready_q;
            assign out_xfer = (state_q != PS_EMPTY) & out_ready;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                unique case (state_q)
                    PS_EMPTY: begin
                        if (in_xfer) begin
                            state_d = PS_ONE;
                            main_d  = in_data;
                        end
                    end
                    PS_ONE: begin
                        if (in_xfer && out_xfer) begin
                            main_d = in_data;
                        end else if (in_xfer) begin
                            state_d = PS_TWO;
                            skid_d  = in_data;
                        end else if (out_xfer) begin
                            state_d = PS_EMPTY;
                            main_d  = '0;
                        end
                    end
                    PS_TWO: begin
                        if (out_xfer) begin
                            state_d = PS_ONE;
                            main_d  = skid_q;
                            skid_d  = '0;
                        end
                    end
                    default: begin
                        state_d = PS_EMPTY;
                        main_d  = '0;
                        skid_d  = '0;
                    end
                endcase
                if (flush) begin
                    state_d = PS_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
                // in_ready is registered by precomputing it from the next state.
                in_ready_d = (state_d != PS_TWO);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q    <= PS_EMPTY;
                    main_q     <= '0;
                    skid_q     <= '0;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    main_q     <= main_d;
                    skid_q     <= skid_d;
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready  = in_ready_q;
            assign out_valid = (state_q != PS_EMPTY);
            assign out_data  = main_q;
        end else begin : g_noskid
            ps_state_e            state_q, state_d;
            logic [PAYLOAD_W-1:0] main_q, main_d;
            logic                 in_rdy;
            logic                 in_xfer, out_xfer;

            assign in_rdy   = (state_q == PS_EMPTY) | out_ready;
            assign in_xfer  = in_valid & in_rdy;
            assign out_xfer = (state_q != PS_EMPTY) & out_ready;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                if (in_xfer) begin
                    // In ONE an in-transfer implies an out-transfer: replace.
                    state_d = PS_ONE;
                    main_d  = in_data;
                end else if (out_xfer) begin
                    state_d = PS_EMPTY;
                    main_d  = '0;
                end
                if (flush) begin
                    state_d = PS_EMPTY;
                    main_d  = '0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= PS_EMPTY;
                    main_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                end
            end

            assign in_ready  = in_rdy;
            assign out_valid = (state_q != PS_EMPTY);
            assign out_data  = main_q;
        end
    endgenerate

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid & ~out_ready),
        .clr (cnt_clr),
        .q   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int unsigned PW = 64;

    logic          clk;
    logic          rst;
    int            checks;
    int            errors;

    // SKID=1, CNT_W=4 instance
    logic          in_valid1, in_ready1, out_valid1, out_ready1, flush1, cnt_clr1;
    logic [PW-1:0] in_data1, out_data1;
    logic [3:0]    stall_cnt1;

    // SKID=0 instance
    logic          in_valid0, in_ready0, out_valid0, out_ready0, flush0, cnt_clr0;
    logic [PW-1:0] in_data0, out_data0;
    logic [15:0]   stall_cnt0;

    pipe_stage_reg #(.PAYLOAD_W(PW), .SKID(1'b1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .flush(flush1), .cnt_clr(cnt_clr1), .stall_cnt(stall_cnt1)
    );

    pipe_stage_reg #(.PAYLOAD_W(PW), .SKID(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .flush(flush0), .cnt_clr(cnt_clr0), .stall_cnt(stall_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // reset held from time 0
        #3;
        checks++; if ({out_valid1, in_ready1, out_data1, stall_cnt1} !== {1'b0, 1'b1, 64'd0, 4'd0}) begin
            errors++; $display("FAIL reset_init1 got v=%0b r=%0b d=%0h c=%0d exp 0 1 0 0", out_valid1, in_ready1, out_data1, stall_cnt1);
        end
        checks++; if ({out_valid0, in_ready0, out_data0, stall_cnt0} !== {1'b0, 1'b1, 64'd0, 16'd0}) begin
            errors++; $display("FAIL reset_init0 got v=%0b r=%0b d=%0h c=%0d exp 0 1 0 0", out_valid0, in_ready0, out_data0, stall_cnt0);
        end
        step();
        rst = 1'b0;
        // fill SKID=1 stage with two payloads
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = 64'h11;
        step();
        in_data1 = 64'h22;
        step();
        in_valid1 = 1'b0;
        checks++; if ({out_valid1, in_ready1, out_data1} !== {1'b1, 1'b0, 64'h11}) begin
            errors++; $display("FAIL reset_fill got v=%0b r=%0b d=%0h exp 1 0 11", out_valid1, in_ready1, out_data1);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if ({out_valid1, in_ready1, out_data1, stall_cnt1} !== {1'b0, 1'b1, 64'd0, 4'd0}) begin
            errors++; $display("FAIL reset_async got v=%0b r=%0b d=%0h c=%0d exp 0 1 0 0", out_valid1, in_ready1, out_data1, stall_cnt1);
        end
        step();
        rst = 1'b0;
        #1;
        checks++; if ({out_valid1, in_ready1, out_data1, stall_cnt1} !== {1'b0, 1'b1, 64'd0, 4'd0}) begin
            errors++; $display("FAIL reset_release got v=%0b r=%0b d=%0h c=%0d exp 0 1 0 0", out_valid1, in_ready1, out_data1, stall_cnt1);
        end
        out_ready1 = 1'b1;
        step();
        checks++; if ({out_valid1, out_data1} !== {1'b0, 64'd0}) begin
            errors++; $display("FAIL reset_nolost got v=%0b d=%0h exp 0 0", out_valid1, out_data1);
        end
    endtask

    task automatic test_stream();
        out_ready1 = 1'b1; out_ready0 = 1'b1;
        in_valid1 = 1'b1;  in_valid0 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data1 = PW'(i); in_data0 = PW'(i);
            step();
            checks++; if ({out_valid1, in_ready1, out_data1} !== {1'b1, 1'b1, PW'(i)}) begin
                errors++; $display("FAIL stream1_%0d got v=%0b r=%0b d=%0h exp 1 1 %0h", i, out_valid1, in_ready1, out_data1, i);
            end
            checks++; if ({out_valid0, in_ready0, out_data0} !== {1'b1, 1'b1, PW'(i)}) begin
                errors++; $display("FAIL stream0_%0d got v=%0b r=%0b d=%0h exp 1 1 %0h", i, out_valid0, in_ready0, out_data0, i);
            end
        end
        in_valid1 = 1'b0; in_valid0 = 1'b0;
        step();
        checks++; if ({out_valid1, out_data1, out_valid0, out_data0} !== {1'b0, 64'd0, 1'b0, 64'd0}) begin
            errors++; $display("FAIL stream_drain got v1=%0b d1=%0h v0=%0b d0=%0h exp 0 0 0 0", out_valid1, out_data1, out_valid0, out_data0);
        end
    endtask

    task automatic test_skid();
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = 64'hA;
        step();
        checks++; if ({out_valid1, in_ready1, out_data1} !== {1'b1, 1'b1, 64'hA}) begin
            errors++; $display("FAIL skid_one got v=%0b r=%0b d=%0h exp 1 1 a", out_valid1, in_ready1, out_data1);
        end
        in_data1 = 64'hB;
        step();
        in_valid1 = 1'b0;
        checks++; if ({out_valid1, in_ready1, out_data1} !== {1'b1, 1'b0, 64'hA}) begin
            errors++; $display("FAIL skid_two got v=%0b r=%0b d=%0h exp 1 0 a", out_valid1, in_ready1, out_data1);
        end
        out_ready1 = 1'b1;
        step();
        checks++; if ({out_valid1, in_ready1, out_data1} !== {1'b1, 1'b1, 64'hB}) begin
            errors++; $display("FAIL skid_drain_b got v=%0b r=%0b d=%0h exp 1 1 b", out_valid1, in_ready1, out_data1);
        end
        step();
        checks++; if ({out_valid1, out_data1} !== {1'b0, 64'd0}) begin
            errors++; $display("FAIL skid_empty got v=%0b d=%0h exp 0 0", out_valid1, out_data1);
        end
    endtask

    task automatic test_noskid_bp();
        out_ready0 = 1'b0; in_valid0 = 1'b1; in_data0 = 64'h5;
        step();
        in_data0 = 64'h6;
        #1;
        checks++; if ({out_valid0, in_ready0, out_data0} !== {1'b1, 1'b0, 64'h5}) begin
            errors++; $display("FAIL noskid_stall got v=%0b r=%0b d=%0h exp 1 0 5", out_valid0, in_ready0, out_data0);
        end
        out_ready0 = 1'b1;
        #1;
        checks++; if (in_ready0 !== 1'b1) begin
            errors++; $display("FAIL noskid_ready_comb got %0b exp 1", in_ready0);
        end
        step();
        in_valid0 = 1'b0;
        checks++; if ({out_valid0, out_data0} !== {1'b1, 64'h6}) begin
            errors++; $display("FAIL noskid_replace got v=%0b d=%0h exp 1 6", out_valid0, out_data0);
        end
        step();
        checks++; if ({out_valid0, out_data0} !== {1'b0, 64'd0}) begin
            errors++; $display("FAIL noskid_empty got v=%0b d=%0h exp 0 0", out_valid0, out_data0);
        end
    endtask

    task automatic test_flush();
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = 64'hC;
        step();
        in_data1 = 64'hD;
        step();
        in_data1 = 64'hE; flush1 = 1'b1;
        step();
        flush1 = 1'b0; in_valid1 = 1'b0;
        checks++; if ({out_valid1, in_ready1, out_data1} !== {1'b0, 1'b1, 64'd0}) begin
            errors++; $display("FAIL flush_two got v=%0b r=%0b d=%0h exp 0 1 0", out_valid1, in_ready1, out_data1);
        end
        out_ready1 = 1'b1;
        step();
        checks++; if ({out_valid1, out_data1} !== {1'b0, 64'd0}) begin
            errors++; $display("FAIL flush_two_gone got v=%0b d=%0h exp 0 0", out_valid1, out_data1);
        end
        // flush in ONE while an in-transfer happens: incoming payload discarded
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = 64'hF;
        step();
        in_data1 = 64'h10; flush1 = 1'b1;
        step();
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        checks++; if ({out_valid1, in_ready1, out_data1} !== {1'b0, 1'b1, 64'd0}) begin
            errors++; $display("FAIL flush_one got v=%0b r=%0b d=%0h exp 0 1 0", out_valid1, in_ready1, out_data1);
        end
        step();
        checks++; if ({out_valid1, out_data1} !== {1'b0, 64'd0}) begin
            errors++; $display("FAIL flush_one_gone got v=%0b d=%0h exp 0 0", out_valid1, out_data1);
        end
    endtask

    task automatic test_counter();
        int unsigned exp;
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = 64'h7; cnt_clr1 = 1'b1;
        step();
        in_valid1 = 1'b0; cnt_clr1 = 1'b0;
        checks++; if (stall_cnt1 !== 4'd0) begin
            errors++; $display("FAIL cnt_start got %0d exp 0", stall_cnt1);
        end
        for (int i = 1; i <= 20; i++) begin
            step();
            exp = (i > 15) ? 15 : i;
            checks++; if (stall_cnt1 !== 4'(exp)) begin
                errors++; $display("FAIL cnt_stall_%0d got %0d exp %0d", i, stall_cnt1, exp);
            end
        end
        cnt_clr1 = 1'b1;
        step();
        cnt_clr1 = 1'b0;
        checks++; if (stall_cnt1 !== 4'd0) begin
            errors++; $display("FAIL cnt_clr got %0d exp 0", stall_cnt1);
        end
        step();
        checks++; if (stall_cnt1 !== 4'd1) begin
            errors++; $display("FAIL cnt_after_clr got %0d exp 1", stall_cnt1);
        end
        flush1 = 1'b1;
        step();
        flush1 = 1'b0;
        checks++; if ({stall_cnt1, out_valid1} !== {4'd2, 1'b0}) begin
            errors++; $display("FAIL cnt_flush got c=%0d v=%0b exp 2 0", stall_cnt1, out_valid1);
        end
        step();
        checks++; if (stall_cnt1 !== 4'd2) begin
            errors++; $display("FAIL cnt_idle got %0d exp 2", stall_cnt1);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        in_valid1 = 1'b0; out_ready1 = 1'b0; flush1 = 1'b0; cnt_clr1 = 1'b0; in_data1 = '0;
        in_valid0 = 1'b0; out_ready0 = 1'b0; flush0 = 1'b0; cnt_clr0 = 1'b0; in_data0 = '0;
        test_reset();
        test_stream();
        test_skid();
        test_noskid_bp();
        test_flush();
        test_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
